// File: rtl/resp_demux5_pkg.sv
// rtl/resp_demux5_pkg.sv - shared constants, select type and channel decode for resp_demux5
package resp_demux5_pkg;

  localparam int RESP_DEMUX5_CH    = 5;
  localparam int RESP_DEMUX5_DEPTH = 2;
  localparam int RESP_DEMUX5_CW    = $clog2(RESP_DEMUX5_DEPTH + 1);

  typedef logic [2:0] resp_demux5_sel_t;

  // Same priority as the five-input mux: bit 2 overrides the low bits.
  function automatic logic [2:0] sel_to_ch(input resp_demux5_sel_t s);
    return s[2] ? 3'd4 : {1'b0, s[1:0]};
  endfunction

endpackage

// File: rtl/resp_demux5_fifo2.sv
// rtl/resp_demux5_fifo2.sv - two-entry per-channel FIFO; head reads 0 while empty
module resp_demux5_fifo2
  import resp_demux5_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic [WIDTH-1:0]          push_data,
  input  logic                      pop,
  output logic [WIDTH-1:0]          head_data,
  output logic                      full,
  output logic                      empty,
  output logic [RESP_DEMUX5_CW-1:0] count
);

  logic [WIDTH-1:0] mem [RESP_DEMUX5_DEPTH];
  logic             rd_ptr;
  logic             wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full      = (count == RESP_DEMUX5_CW'(RESP_DEMUX5_DEPTH));
  assign empty     = (count == '0);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + RESP_DEMUX5_CW'(do_push) - RESP_DEMUX5_CW'(do_pop);
    end
  end

endmodule

// File: rtl/resp_demux5.sv
// rtl/resp_demux5.sv - 1-to-5 response demux with a 2-deep FIFO per channel
// Optional illegal-select detection (sel 5-7) under `RESP_DEMUX5_ERR_EN.
module resp_demux5
  import resp_demux5_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [WIDTH-1:0]                in_data,
  input  resp_demux5_sel_t                in_sel,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [RESP_DEMUX5_CH*WIDTH-1:0] out_data,
  output logic [RESP_DEMUX5_CH-1:0]       out_valid,
  input  logic [RESP_DEMUX5_CH-1:0]       out_ready,
  output logic                            err_sticky,
  input  logic                            err_clr
);

  logic [2:0]                                     tgt;
  logic                                           illegal;
  logic [RESP_DEMUX5_CH-1:0]                      full;
  logic [RESP_DEMUX5_CH-1:0]                      empty;
  logic [RESP_DEMUX5_CH-1:0]                      push;
  logic [RESP_DEMUX5_CH-1:0][RESP_DEMUX5_CW-1:0]  unused_count;

  assign tgt = sel_to_ch(in_sel);

`ifdef RESP_DEMUX5_ERR_EN
  assign illegal = in_sel[2] && (in_sel[1:0] != 2'b00);
`else
  assign illegal = 1'b0;
`endif

  // Full is judged on the pre-edge count, so a same-cycle pop never frees a slot.
  always_comb begin
    push     = '0;
    in_ready = illegal || !full[tgt];
    if (in_valid && in_ready && !illegal) begin
      push[tgt] = 1'b1;
    end
  end

  for (genvar i = 0; i < RESP_DEMUX5_CH; i++) begin : g_ch
    resp_demux5_fifo2 #(.WIDTH(WIDTH)) u_fifo (
      .clk       (clk),
      .rst_n     (reset_n),
      .push      (push[i]),
      .push_data (in_data),
      .pop       (out_ready[i]),
      .head_data (out_data[i*WIDTH +: WIDTH]),
      .full      (full[i]),
      .empty     (empty[i]),
      .count     (unused_count[i])
    );
    assign out_valid[i] = !empty[i];
  end

`ifdef RESP_DEMUX5_ERR_EN
  logic err_q;

  // A new illegal word outranks a same-cycle clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else if (in_valid && illegal) begin
      err_q <= 1'b1;
    end else if (err_clr) begin
      err_q <= 1'b0;
    end
  end

  assign err_sticky = err_q;
`else
  logic unused_err_clr;

  assign unused_err_clr = err_clr;
  assign err_sticky     = 1'b0;
`endif

endmodule

// File: tb/tb_resp_demux5.sv
// tb/tb_resp_demux5.sv - directed and random scoreboard bench for resp_demux5
module tb_resp_demux5;

  localparam int W = 32;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [W-1:0]    in_data;
  logic [2:0]      in_sel;
  logic            in_valid;
  logic            in_ready;
  logic [5*W-1:0]  out_data;
  logic [4:0]      out_valid;
  logic [4:0]      out_ready;
  logic            err_sticky;
  logic            err_clr;

  int vectors    = 0;
  int miscompares = 0;

  logic [W-1:0] sbq [5][$];
  logic         exp_err;

  resp_demux5 #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .err_sticky (err_sticky),
    .err_clr    (err_clr)
  );

  always #5 clk = ~clk;

  function automatic int ch_of(input logic [2:0] s);
    if (s[2]) return 4;
    return int'(s[1:0]);
  endfunction

  function automatic logic [W-1:0] head(input int ch);
    return out_data[ch*W +: W];
  endfunction

  task automatic idle_inputs();
    in_valid  = 1'b0;
    in_sel    = 3'd0;
    in_data   = '0;
    out_ready = 5'b0;
    err_clr   = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) sbq[i].delete();
    exp_err = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    idle_inputs();
    reset_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_out_valid: got %b expected 00000", out_valid);
    end
    vectors++;
    if (out_data !== '0) begin
      miscompares++;
      $display("FAIL reset_out_data: got %h expected 0", out_data);
    end
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    vectors++;
    if (err_sticky !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_err_sticky: got %b expected 0", err_sticky);
    end
    do_reset();
  endtask

  task automatic test_single_push();
    logic [W-1:0] exp;
    do_reset();
    @(negedge clk);
    in_valid = 1'b1; in_sel = 3'd2; in_data = 32'hA5A5A5A5;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL single_in_ready: got %b expected 1", in_ready);
    end
    sbq[2].push_back(in_data);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 5'b00100) begin
      miscompares++;
      $display("FAIL single_out_valid: got %b expected 00100", out_valid);
    end
    exp = sbq[2].pop_front();
    vectors++;
    if (head(2) !== exp) begin
      miscompares++;
      $display("FAIL single_out_data: got %h expected %h", head(2), exp);
    end
    out_ready = 5'b00100;
    @(negedge clk);
    out_ready = 5'b0;
    #1;
    vectors++;
    if (out_valid !== 5'b0) begin
      miscompares++;
      $display("FAIL single_drain: got %b expected 00000", out_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] exp;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b1; in_sel = 3'd1; in_data = 32'h1000_0000 + W'(k);
      #1;
      vectors++;
      if (in_ready !== (k < 2)) begin
        miscompares++;
        $display("FAIL bp_in_ready_%0d: got %b expected %b", k, in_ready, k < 2);
      end
      if (k < 2) sbq[1].push_back(in_data);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 5'b00010;
    for (int k = 0; k < 2; k++) begin
      #1;
      exp = sbq[1].pop_front();
      vectors++;
      if (out_valid[1] !== 1'b1 || head(1) !== exp) begin
        miscompares++;
        $display("FAIL bp_drain_%0d: got v=%b %h expected v=1 %h", k, out_valid[1], head(1), exp);
      end
      @(negedge clk);
    end
    #1;
    vectors++;
    if (out_valid[1] !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_empty: got %b expected 0", out_valid[1]);
    end
    out_ready = 5'b0;
  endtask

  task automatic test_no_bypass();
    logic [W-1:0] exp;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      in_valid = 1'b1; in_sel = 3'd3; in_data = 32'h3300_0000 + W'(k);
      sbq[3].push_back(in_data);
    end
    @(negedge clk);
    in_data = 32'h3300_00FF; out_ready = 5'b01000;
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL nobypass_in_ready: got %b expected 0", in_ready);
    end
    exp = sbq[3].pop_front();
    vectors++;
    if (head(3) !== exp) begin
      miscompares++;
      $display("FAIL nobypass_head0: got %h expected %h", head(3), exp);
    end
    @(negedge clk);
    out_ready = 5'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL nobypass_retry_ready: got %b expected 1", in_ready);
    end
    sbq[3].push_back(in_data);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 5'b01000;
    for (int k = 0; k < 2; k++) begin
      #1;
      exp = sbq[3].pop_front();
      vectors++;
      if (out_valid[3] !== 1'b1 || head(3) !== exp) begin
        miscompares++;
        $display("FAIL nobypass_drain_%0d: got v=%b %h expected v=1 %h", k, out_valid[3], head(3), exp);
      end
      @(negedge clk);
    end
    out_ready = 5'b0;
  endtask

  task automatic test_illegal_sel();
    do_reset();
    @(negedge clk);
    in_valid = 1'b1; in_sel = 3'd6; in_data = 32'h6666_6666;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL sel6_in_ready: got %b expected 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
`ifdef RESP_DEMUX5_ERR_EN
    vectors++;
    if (out_valid !== 5'b0 || err_sticky !== 1'b1) begin
      miscompares++;
      $display("FAIL sel6_drop: got v=%b err=%b expected v=00000 err=1", out_valid, err_sticky);
    end
    err_clr = 1'b1;
    @(negedge clk);
    #1;
    vectors++;
    if (err_sticky !== 1'b0) begin
      miscompares++;
      $display("FAIL sel6_clr: got %b expected 0", err_sticky);
    end
    in_valid = 1'b1; in_sel = 3'd7;
    @(negedge clk);
    in_valid = 1'b0; err_clr = 1'b0;
    #1;
    vectors++;
    if (err_sticky !== 1'b1) begin
      miscompares++;
      $display("FAIL sel7_clr_race: got %b expected 1", err_sticky);
    end
`else
    vectors++;
    if (out_valid !== 5'b10000 || head(4) !== 32'h6666_6666 || err_sticky !== 1'b0) begin
      miscompares++;
      $display("FAIL sel6_route: got v=%b %h err=%b expected v=10000 66666666 err=0",
               out_valid, head(4), err_sticky);
    end
    err_clr = 1'b1;
    @(negedge clk);
    #1;
    vectors++;
    if (err_sticky !== 1'b0) begin
      miscompares++;
      $display("FAIL sel6_errtie: got %b expected 0", err_sticky);
    end
`endif
    err_clr = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    @(negedge clk);
    in_valid = 1'b1; in_sel = 3'd0; in_data = 32'h0A0A_0A0A;
    @(negedge clk);
    in_sel = 3'd4; in_data = 32'h4B4B_4B4B;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 5'b10001) begin
      miscompares++;
      $display("FAIL areset_pre: got %b expected 10001", out_valid);
    end
    #1;
    reset_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 5'b0 || out_data !== '0) begin
      miscompares++;
      $display("FAIL areset_now: got v=%b d=%h expected v=00000 d=0", out_valid, out_data);
    end
    @(negedge clk);
    reset_n = 1'b1;
    out_ready = 5'b11111;
    for (int k = 0; k < 3; k++) begin
      #1;
      vectors++;
      if (in_ready !== 1'b1 || out_valid !== 5'b0) begin
        miscompares++;
        $display("FAIL areset_after_%0d: got rdy=%b v=%b expected rdy=1 v=00000", k, in_ready, out_valid);
      end
      @(negedge clk);
    end
    out_ready = 5'b0;
    for (int i = 0; i < 5; i++) sbq[i].delete();
  endtask

  task automatic test_random();
    int  ch;
    logic legal;
    logic exp_rdy;
    logic [W-1:0] exp;
    do_reset();
    for (int cyc = 0; cyc < 10010; cyc++) begin
      @(negedge clk);
      if (cyc < 10000) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        in_sel    = 3'($urandom_range(0, 7));
        in_data   = $urandom;
        out_ready = 5'($urandom);
        err_clr   = ($urandom_range(0, 15) == 0);
      end else begin
        idle_inputs();
        out_ready = 5'b11111;
      end
      #1;
      for (int i = 0; i < 5; i++) begin
        vectors++;
        if (out_valid[i] !== (sbq[i].size() > 0)) begin
          miscompares++;
          $display("FAIL rnd_valid_ch%0d cyc %0d: got %b expected %b", i, cyc, out_valid[i], sbq[i].size() > 0);
        end else if (sbq[i].size() > 0 && head(i) !== sbq[i][0]) begin
          miscompares++;
          $display("FAIL rnd_data_ch%0d cyc %0d: got %h expected %h", i, cyc, head(i), sbq[i][0]);
        end
      end
      ch = ch_of(in_sel);
`ifdef RESP_DEMUX5_ERR_EN
      legal = !(in_sel[2] && in_sel[1:0] != 2'b00);
`else
      legal = 1'b1;
`endif
      exp_rdy = !legal || (sbq[ch].size() < 2);
      vectors++;
      if (in_ready !== exp_rdy) begin
        miscompares++;
        $display("FAIL rnd_in_ready cyc %0d: got %b expected %b", cyc, in_ready, exp_rdy);
      end
      vectors++;
      if (err_sticky !== exp_err) begin
        miscompares++;
        $display("FAIL rnd_err cyc %0d: got %b expected %b", cyc, err_sticky, exp_err);
      end
      for (int i = 0; i < 5; i++)
        if (out_ready[i] && sbq[i].size() > 0) exp = sbq[i].pop_front();
      if (in_valid && exp_rdy && legal) sbq[ch].push_back(in_data);
`ifdef RESP_DEMUX5_ERR_EN
      if (in_valid && !legal) exp_err = 1'b1;
      else if (err_clr)       exp_err = 1'b0;
`endif
    end
    @(negedge clk);
    #1;
    vectors++;
    if (out_valid !== 5'b0 || sbq[0].size() + sbq[1].size() + sbq[2].size() + sbq[3].size() + sbq[4].size() != 0) begin
      miscompares++;
      $display("FAIL rnd_final_empty: got v=%b expected v=00000 with empty scoreboard", out_valid);
    end
  endtask

  initial begin
    reset_n = 1'b1;
    exp_err = 1'b0;
    idle_inputs();
    test_reset();
    test_single_push();
    test_backpressure();
    test_no_bypass();
    test_illegal_sel();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/resp_demux5.md
RESP_DEMUX5 -- requirements
Module: resp_demux5

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the data width of every data port.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 in_data  input  WIDTH  SHALL carry the producer's data word.
REQ-005 in_sel  input  3  SHALL carry the destination channel select for in_data.
REQ-006 in_valid  input  1  SHALL mark in_data/in_sel as valid.
REQ-007 in_ready  output  1  SHALL indicate the word will be accepted this cycle.
REQ-008 out_data  output  5 x WIDTH  SHALL present the head word of each channel's buffer.
REQ-009 out_valid  output  5  SHALL mark each channel's out_data as valid.
REQ-010 out_ready  input  5  SHALL indicate each consumer takes its head word this cycle.
REQ-011 err_sticky  output  1  SHALL flag that an illegal select was seen (RESP_DEMUX5_ERR_EN only).
REQ-012 err_clr  input  1  SHALL clear err_sticky (RESP_DEMUX5_ERR_EN only).

Function
REQ-013 Decode SHALL mirror the five-input mux: in_sel[2]=1 selects channel 4; otherwise in_sel[1:0] selects channels 0-3.
REQ-014 Each channel SHALL own a 2-entry FIFO (count 0..2), order preserved within a channel; no ordering guarantee across channels.
REQ-015 in_ready SHALL be combinational: 1 iff the decoded target FIFO count < 2, independent of in_valid.
REQ-016 Push SHALL occur when in_valid && in_ready.
REQ-017 A full target SHALL hold in_ready=0 even if that channel pops in the same cycle (no full-bypass).
REQ-018 Latency SHALL be 1 cycle: a word pushed at edge N SHALL appear with out_valid=1 after edge N; there SHALL be no combinational in-to-out path.
REQ-019 out_valid[i] SHALL be 1 iff FIFO i count > 0; pop when out_valid[i] && out_ready[i].
REQ-020 A simultaneous push and pop on the same channel with count 1 SHALL leave count 1 and present the new word next.
REQ-021 Pops on multiple channels in one cycle SHALL all occur; out_ready on an empty channel SHALL be ignored.
REQ-022 out_data[i] SHALL be stable while out_valid[i]=1 and out_ready[i]=0.

Reset
REQ-023 reset_n low SHALL asynchronously empty all FIFOs: out_valid=0, err_sticky=0; out_data SHALL be 0.
REQ-024 in_ready SHALL read 1 during and after reset (all FIFOs empty).
REQ-025 Reset mid-operation SHALL discard all buffered words, with no partial pops.

Configuration
REQ-026 With RESP_DEMUX5_ERR_EN defined, in_sel values 5-7 SHALL be illegal: in_ready=1, the word is consumed and dropped, and err_sticky is set after that edge.
REQ-027 With RESP_DEMUX5_ERR_EN defined, err_clr=1 SHALL clear err_sticky; a simultaneous new illegal push SHALL win (flag set).
REQ-028 Without RESP_DEMUX5_ERR_EN, in_sel 5-7 SHALL route to channel 4 per REQ-013, err_sticky SHALL be tied 0 and err_clr ignored.

Structure
REQ-029 Package resp_demux5_pkg SHALL hold RESP_DEMUX5_CH=5, RESP_DEMUX5_DEPTH=2 and typedef resp_demux5_sel_t (3-bit).
REQ-030 The per-channel buffer SHALL be sub-module resp_demux5_fifo2 (WIDTH parameter, push/pop/full/empty/count), instantiated 5 times.

Verification
REQ-031 Push 0xA5A5A5A5 with sel=2, all out_ready=0 -> next cycle out_valid=5'b00100, out_data[2]=0xA5A5A5A5.
REQ-032 Push 3 words with sel=1 and out_ready[1]=0 -> third word sees in_ready=0; releasing out_ready[1] drains words 1 and 2 in order.
REQ-033 Channel 3 full, pop and push asserted together -> in_ready=0 that cycle; the push succeeds the following cycle.
REQ-034 sel=6 with the macro: word dropped, out_valid unchanged, err_sticky=1; err_clr -> 0. Without the macro: word appears on channel 4.
REQ-035 Assert reset_n low between clock edges with 2 words buffered -> out_valid=0 immediately; after release in_ready=1 and no stale data appears.
REQ-036 Random in_sel/in_valid/out_ready over 10k cycles -> scoreboard per channel: no loss, duplication or reordering.
